// File: rtl/nano_mem_arbiter.sv
// Two-requester (IF / D) arbiter for one single-ported memory with a response watchdog.
// Define NANO_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority.
module nano_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_ready,
    output logic              o_if_rvalid,
    output logic [31:0]       o_if_rdata,
    output logic              o_if_err,
    input  logic              i_d_req,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic              i_d_we,
    input  logic [3:0]        i_d_be,
    input  logic [31:0]       i_d_wdata,
    output logic              o_d_ready,
    output logic              o_d_rvalid,
    output logic [31:0]       o_d_rdata,
    output logic              o_d_err,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_busy
);

    localparam int WD_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    logic              r_sel_d;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [WD_W-1:0]   r_wd;
    logic              r_if_rvalid;
    logic [31:0]       r_if_rdata;
    logic              r_if_err;
    logic              r_d_rvalid;
    logic [31:0]       r_d_rdata;
    logic              r_d_err;

    logic              w_pick_d;
    logic              w_accept;
    logic              w_timeout;
    logic              w_resp_fire;
    logic              w_resp_err;
    logic [31:0]       w_resp_data;

`ifdef NANO_ARB_RR_EN
    logic r_last_d;

    // On contention, the requester that did not win last time goes first.
    assign w_pick_d = i_d_req & (~i_if_req | ~r_last_d);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_d <= 1'b0;
        end else if (w_accept) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    assign w_pick_d = i_d_req;
`endif

    assign w_accept   = (r_state == S_IDLE) & (i_if_req | i_d_req);
    // Ready is gated by reset so every output reads 0 while reset is held.
    assign o_d_ready  = i_rst_n & (r_state == S_IDLE) & w_pick_d;
    assign o_if_ready = i_rst_n & (r_state == S_IDLE) & i_if_req & ~w_pick_d;

    assign w_timeout   = (TIMEOUT != 0) && (r_wd == WD_LAST);
    assign w_resp_fire = (r_state == S_WAIT) & (i_mem_rvalid | w_timeout);
    assign w_resp_err  = ~i_mem_rvalid;
    assign w_resp_data = (i_mem_rvalid & ~r_we) ? i_mem_rdata : 32'h0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_sel_d     <= 1'b0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_be        <= 4'h0;
            r_wdata     <= 32'h0;
            r_wd        <= '0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= 32'h0;
            r_if_err    <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= 32'h0;
            r_d_err     <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sel_d <= w_pick_d;
                        if (w_pick_d) begin
                            r_addr  <= i_d_addr;
                            r_we    <= i_d_we;
                            r_be    <= i_d_be;
                            r_wdata <= i_d_wdata;
                        end else begin
                            r_addr  <= i_if_addr;
                            r_we    <= 1'b0;
                            r_be    <= 4'hF;
                            r_wdata <= 32'h0;
                        end
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_mem_gnt) begin
                        r_wd    <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_resp_fire) begin
                        if (r_sel_d) begin
                            r_d_rvalid <= 1'b1;
                            r_d_rdata  <= w_resp_data;
                            r_d_err    <= w_resp_err;
                        end else begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= w_resp_data;
                            r_if_err    <= w_resp_err;
                        end
                        r_state <= S_RESP;
                    end else if (r_wd != WD_MAX) begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mem_req   = (r_state == S_REQ);
    assign o_mem_addr  = r_addr;
    assign o_mem_we    = r_we;
    assign o_mem_be    = r_be;
    assign o_mem_wdata = r_wdata;
    assign o_busy      = (r_state != S_IDLE);

    assign o_if_rvalid = r_if_rvalid;
    assign o_if_rdata  = r_if_rdata;
    assign o_if_err    = r_if_err;
    assign o_d_rvalid  = r_d_rvalid;
    assign o_d_rdata   = r_d_rdata;
    assign o_d_err     = r_d_err;

endmodule

// File: tb/tb_nano_mem_arbiter.sv
// Self-checking bench for nano_mem_arbiter: vector table, contention, timeout and reset sequences.
module tb_nano_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_ready, if_rvalid, if_err;
    logic [31:0]       if_rdata;
    logic              d_req = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic              d_we = 1'b0;
    logic [3:0]        d_be = 4'h0;
    logic [31:0]       d_wdata = 32'h0;
    logic              d_ready, d_rvalid, d_err;
    logic [31:0]       d_rdata;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [31:0]       mem_rdata = 32'h0;
    logic              busy;

    always #5 clk = ~clk;

    nano_mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ready(if_ready),
        .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata), .o_if_err(if_err),
        .i_d_req(d_req), .i_d_addr(d_addr), .i_d_we(d_we), .i_d_be(d_be),
        .i_d_wdata(d_wdata), .o_d_ready(d_ready), .o_d_rvalid(d_rvalid),
        .o_d_rdata(d_rdata), .o_d_err(d_err),
        .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_we(mem_we),
        .o_mem_be(mem_be), .o_mem_wdata(mem_wdata), .i_mem_gnt(mem_gnt),
        .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata), .o_busy(busy)
    );

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          gnt_dly;
        int          rv_dly;   // -1: memory never answers
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: every response pulse must match the oldest expected response.
    always @(negedge clk) begin
        #2;
        if (rst_n && (if_rvalid || d_rvalid)) begin
            if (if_rvalid && d_rvalid) begin
                chk("sb_both_rvalid", 2'b11, 2'b01);
            end else if (sb.size() == 0) begin
                chk("sb_unexpected_rvalid", {d_rvalid, if_rvalid}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_port", {31'h0, d_rvalid}, {31'h0, e.is_d});
                chk("sb_rdata", d_rvalid ? d_rdata : if_rdata, e.rdata);
                chk("sb_err", d_rvalid ? d_err : if_err, e.err);
            end
        end
    end

    task automatic run_txn(input vec_t v);
        exp_t e;
        bit   to;
        int   wait_cycles;
        @(negedge clk);
        if_addr = v.addr; d_addr = v.addr; d_we = v.we; d_be = v.be; d_wdata = v.wdata;
        if (v.is_d) d_req = 1'b1; else if_req = 1'b1;
        #1;
        chk("accept_ready", {d_ready, if_ready}, v.is_d ? 2'b10 : 2'b01);
        chk("accept_idle", busy, 1'b0);
        for (int k = 0; k <= v.gnt_dly; k++) begin
            @(negedge clk);
            if_req = 1'b0; d_req = 1'b0; mem_gnt = (k == v.gnt_dly);
            #1;
            chk("req_mem_req", mem_req, 1'b1);
            chk("req_mem_addr", mem_addr, v.addr);
            chk("req_mem_we", mem_we, v.is_d & v.we);
            chk("req_mem_be", mem_be, v.is_d ? v.be : 4'hF);
            chk("req_mem_wdata", mem_wdata, v.is_d ? v.wdata : 32'h0);
        end
        to = (v.rv_dly < 0) || (v.rv_dly >= TIMEOUT);
        wait_cycles = to ? TIMEOUT : v.rv_dly + 1;
        e.is_d  = v.is_d;
        e.err   = to;
        e.rdata = (to || (v.is_d && v.we)) ? 32'h0 : v.rdata;
        sb.push_back(e);
        for (int w = 0; w < wait_cycles; w++) begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = (w == v.rv_dly);
            mem_rdata  = (w == v.rv_dly) ? v.rdata : (32'hBAD0_0000 | w);
            #1;
            chk("wait_no_req", {mem_req, d_rvalid, if_rvalid}, 3'b000);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("resp_pulse", {d_rvalid, if_rvalid}, v.is_d ? 2'b10 : 2'b01);
        @(negedge clk);
        #1;
        chk("post_idle", {busy, d_rvalid, if_rvalid}, 3'b000);
        chk("rdata_hold", v.is_d ? d_rdata : if_rdata, e.rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //            is_d  addr          we    be     wdata         gnt rv  rdata
        vecs[0] = '{1'b0, 32'h0000_0100, 1'b1, 4'h3, 32'h0000_0077, 0, 0,  32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'h0000_0200, 1'b1, 4'h3, 32'h0000_1234, 3, 0,  32'hFFFF_FFFF};
        vecs[2] = '{1'b1, 32'h0000_0300, 1'b0, 4'hF, 32'h0000_0000, 1, 2,  32'hCAFE_F00D};
        vecs[3] = '{1'b1, 32'h0000_0400, 1'b0, 4'hF, 32'h0000_0000, 0, -1, 32'h1111_1111};
        vecs[4] = '{1'b0, 32'h0000_0500, 1'b0, 4'hF, 32'h0000_0000, 0, 15, 32'h5A5A_A5A5};
        vecs[5] = '{1'b0, 32'h0000_0600, 1'b0, 4'hF, 32'h0000_0000, 2, -1, 32'h2222_2222};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctrl", {busy, mem_req, mem_we, if_rvalid, d_rvalid, if_err, d_err}, 7'h0);
        chk("rst_fields", {mem_be, mem_addr}, 36'h0);
        chk("rst_rdata", {if_rdata, d_rdata}, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i]);
            if (i == 3) begin
                // Stray gnt/rvalid while idle must not create activity.
                @(negedge clk);
                mem_rvalid = 1'b1; mem_gnt = 1'b1;
                #1;
                chk("stray_idle", busy, 1'b0);
                @(negedge clk);
                mem_rvalid = 1'b0; mem_gnt = 1'b0;
                #1;
                chk("stray_no_resp", {busy, d_rvalid, if_rvalid}, 3'b000);
            end
        end

        // Contention: both requesters held for three transactions.
        for (int t = 0; t < 3; t++) begin
            bit exp_d;
`ifdef NANO_ARB_RR_EN
            exp_d = (t != 1);
`else
            exp_d = 1'b1;
`endif
            @(negedge clk);
            if_req = 1'b1; d_req = 1'b1; if_addr = 32'h1000;
            d_addr = 32'h2000 + 32'(t * 4); d_we = 1'b0; d_be = 4'hF;
            #1;
            chk("cont_ready", {d_ready, if_ready}, exp_d ? 2'b10 : 2'b01);
            @(negedge clk);
            mem_gnt = 1'b1;
            #1;
            chk("cont_addr", mem_addr, exp_d ? (32'h2000 + 32'(t * 4)) : 32'h1000);
            chk("cont_req_noready", {d_ready, if_ready}, 2'b00);
            sb.push_back('{exp_d, 32'hA000 + 32'(t), 1'b0});
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA000 + 32'(t);
            @(negedge clk);
            mem_rvalid = 1'b0;
            #1;
            chk("cont_resp_noready", {d_ready, if_ready}, 2'b00);
            chk("cont_resp", {d_rvalid, if_rvalid}, exp_d ? 2'b10 : 2'b01);
        end
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0;

        // Reset while waiting for the memory response.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h700;
        @(negedge clk);
        if_req = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        chk("rst_pre_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ctrl", {busy, mem_req, mem_we, if_rvalid, d_rvalid, if_err, d_err}, 7'h0);
        chk("arst_fields", {mem_be, mem_addr}, 36'h0);
        chk("arst_rdata", {if_rdata, d_rdata}, 64'h0);
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h9999_9999;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("post_rst_idle", {busy, d_rvalid, if_rvalid}, 3'b000);
        run_txn('{1'b0, 32'h0000_0800, 1'b0, 4'hF, 32'h0, 0, 1, 32'h1357_9BDF});

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
